qdrc_phy_data_align: RTL and testbench

- Sits directly downstream of the QDR PHY per-bit IODELAY trainer and consumes its per-bit half-word `aligned` status plus the raw IDDR rise/fall words.
- Re-pairs half-words on bits flagged misaligned so every bit presents the same word on the same cycle.
- Calibrates read latency by issuing training reads and timing the return of a known pattern, then generates `data_valid` for user reads from the read strobe delayed by the measured latency.

---
 rtl/qdrc_phy_data_align.sv | 182 ++++++++++++++++++
 tb/tb_qdrc_phy_data_align.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdrc_phy_data_align.sv
// rtl/qdrc_phy_data_align.sv - QDR read half-word re-pairing, read-latency calibration and data_valid generation
// Optional macro QDRC_DATA_ALIGN_PIPE_EN adds an output register stage on data_rise/data_fall.
module qdrc_phy_data_align #(
    parameter int DATA_WIDTH   = 36,
    parameter int LAT_WIDTH    = 4,
    parameter int VERIFY_COUNT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  align_start,
    input  logic [DATA_WIDTH-1:0] aligned,
    input  logic [DATA_WIDTH-1:0] q_rise,
    input  logic [DATA_WIDTH-1:0] q_fall,
    input  logic                  rd_strb,
    output logic                  cal_rd_req,
    output logic [DATA_WIDTH-1:0] data_rise,
    output logic [DATA_WIDTH-1:0] data_fall,
    output logic                  data_valid,
    output logic                  cal_done,
    output logic                  cal_fail,
    output logic [LAT_WIDTH-1:0]  latency,
    output logic [2:0]            align_state_prb
);
    localparam int DEPTH = 2**LAT_WIDTH;
    localparam int VC_W  = (VERIFY_COUNT > 1) ? $clog2(VERIFY_COUNT) : 1;
    localparam logic [LAT_WIDTH-1:0] CNT_LAST = LAT_WIDTH'(DEPTH - 2);
    localparam logic [VC_W-1:0]      VC_LAST  = VC_W'(VERIFY_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_VISSUE = 3'd3,
        ST_VWAIT  = 3'd4,
        ST_DONE   = 3'd5,
        ST_FAIL   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [LAT_WIDTH-1:0]  cnt_q, cnt_d, lat_q, lat_d, cnt_inc, tap_sel;
    logic [VC_W-1:0]       vcnt_q, vcnt_d;
    logic                  req_q, req_d, done_q, done_d, fail_q, fail_d;
    logic [DATA_WIDTH-1:0] q_fall_dly_q, rise_q, rise_d, fall_q, fall_d;
    logic [DEPTH-1:0]      tap_q, tap_d;
    logic                  start, match;

    // Swapped bits take their first half-word from the previous cycle's fall sample.
    always_comb begin
        rise_d = (aligned & q_rise) | (~aligned & q_fall_dly_q);
        fall_d = (aligned & q_fall) | (~aligned & q_rise);
    end

`ifdef QDRC_DATA_ALIGN_PIPE_EN
    logic [DATA_WIDTH-1:0] rise_p_q, fall_p_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_p_q <= '0;
            fall_p_q <= '0;
        end else begin
            rise_p_q <= rise_q;
            fall_p_q <= fall_q;
        end
    end
    assign data_rise = rise_p_q;
    assign data_fall = fall_p_q;
`else
    assign data_rise = rise_q;
    assign data_fall = fall_q;
`endif

    // Matching on the outputs makes any extra pipeline stage part of the measured latency.
    assign match   = (&data_rise) & ~(|data_fall);
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vcnt_d  = vcnt_q;
        lat_d   = lat_q;
        req_d   = 1'b0;
        done_d  = done_q;
        fail_d  = fail_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (align_start) begin
                    start   = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    lat_d   = '0;
                    req_d   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (match) begin
                    lat_d   = cnt_inc;
                    vcnt_d  = '0;
                    req_d   = 1'b1;
                    state_d = ST_VISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    fail_d  = 1'b1;
                    state_d = ST_FAIL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_VISSUE: begin
                cnt_d   = '0;
                state_d = ST_VWAIT;
            end
            ST_VWAIT: begin
                if (match && cnt_inc == lat_q) begin
                    if (vcnt_q == VC_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        vcnt_d  = vcnt_q + 1'b1;
                        req_d   = 1'b1;
                        state_d = ST_VISSUE;
                    end
                end else if (match || cnt_inc == lat_q) begin
                    fail_d  = 1'b1;
                    state_d = ST_FAIL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are only admitted once calibrated, so pre-calibration reads never surface.
    always_comb begin
        tap_d = {tap_q[DEPTH-2:0], rd_strb & done_q};
        if (start) begin
            tap_d = '0;
        end
    end

    assign tap_sel    = lat_q - 1'b1;
    assign data_valid = done_q & tap_q[tap_sel];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            vcnt_q       <= '0;
            lat_q        <= '0;
            req_q        <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            q_fall_dly_q <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            tap_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vcnt_q       <= vcnt_d;
            lat_q        <= lat_d;
            req_q        <= req_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            q_fall_dly_q <= q_fall;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            tap_q        <= tap_d;
        end
    end

    assign cal_rd_req      = req_q;
    assign cal_done        = done_q;
    assign cal_fail        = fail_q;
    assign latency         = lat_q;
    assign align_state_prb = state_q;

endmodule

// File: tb/tb_qdrc_phy_data_align.sv
// tb/tb_qdrc_phy_data_align.sv - self-checking bench for qdrc_phy_data_align
`timescale 1ns/1ps
module tb_qdrc_phy_data_align;
    localparam int DW = 36;
    localparam int LW = 4;
`ifdef QDRC_DATA_ALIGN_PIPE_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n, align_start, rd_strb;
    logic [DW-1:0] aligned, q_rise, q_fall;
    logic          cal_rd_req, data_valid, cal_done, cal_fail;
    logic [DW-1:0] data_rise, data_fall;
    logic [LW-1:0] latency;
    logic [2:0]    align_state_prb;

    always #5 clk = ~clk;

    qdrc_phy_data_align #(.DATA_WIDTH(DW), .LAT_WIDTH(LW), .VERIFY_COUNT(8)) dut (
        .clk(clk), .reset_n(reset_n), .align_start(align_start), .aligned(aligned),
        .q_rise(q_rise), .q_fall(q_fall), .rd_strb(rd_strb), .cal_rd_req(cal_rd_req),
        .data_rise(data_rise), .data_fall(data_fall), .data_valid(data_valid),
        .cal_done(cal_done), .cal_fail(cal_fail), .latency(latency),
        .align_state_prb(align_state_prb)
    );

    int            n_tests = 0, n_fail = 0;
    int            cyc = 0;
    int            chk_from = 1 << 30;
    logic [DW-1:0] al = '1;
    logic [DW-1:0] bg_r[int];
    logic [DW-1:0] bg_f[int];
    bit            pat_at[int];
    bit            sent[int];
    int            resp[9];
    int            nreads = 0, first_req = 0, last_req = 0;
    int            dv_lat = 0;
    bit            tb_done = 0, start_req = 0, strb_req = 0, strb_rand = 0;

    typedef struct {
        int r0; int bad_idx; int rbad; bit mid;
        bit e_done; bit e_fail; int e_lat; int e_reads;
    } vec_t;

    function automatic logic [DW-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic void ensure_bg(int n);
        if (!bg_r.exists(n)) begin
            bg_r[n] = rnd();
            bg_f[n] = rnd() | 36'd1;
        end
    endfunction

    function automatic logic [DW-1:0] word_r(int n);
        ensure_bg(n);
        if (pat_at.exists(n)) return {DW{1'b1}};
        return bg_r[n];
    endfunction

    function automatic logic [DW-1:0] word_f(int n);
        ensure_bg(n);
        if (pat_at.exists(n)) return {DW{1'b0}};
        return bg_f[n];
    endfunction

    // Outcome of a calibration given the return delay of each of the nine training reads.
    function automatic void model(input int r[9], output bit d, output bit f, output int lat, output int rd);
        d = 0; f = 1; lat = 0; rd = 1;
        if (r[0] <= 0 || r[0] + P > 15) return;
        lat = r[0] + P;
        for (int j = 1; j < 9; j++) begin
            rd = j + 1;
            if (r[j] != r[0]) return;
        end
        d = 1; f = 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [DW-1:0] wr, wf, w2r;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc - P >= chk_from) begin
            chk("data_rise", data_rise, word_r(cyc - P));
            chk("data_fall", data_fall, word_f(cyc - P));
        end
        chk("data_valid", data_valid, (dv_lat != 0 && sent.exists(cyc - dv_lat)) ? 1 : 0);
        chk("done_fail_excl", cal_done & cal_fail, 0);
        if (cal_rd_req) begin
            if (nreads == 0) first_req = cyc;
            last_req = cyc;
            if (nreads < 9 && resp[nreads] > 0) pat_at[cyc + resp[nreads]] = 1;
            nreads++;
        end
        wr  = word_r(cyc + 1);
        wf  = word_f(cyc + 1);
        w2r = word_r(cyc + 2);
        aligned     = al;
        q_rise      = (al & wr) | (~al & wf);
        q_fall      = (al & wf) | (~al & w2r);
        align_start = start_req;
        start_req   = 0;
        rd_strb     = strb_rand ? (!cal_done && $urandom_range(0, 1) == 1) : strb_req;
        if (rd_strb && tb_done) sent[cyc] = 1;
    endtask

    task automatic set_aligned(input logic [DW-1:0] v);
        al = v;
        chk_from = cyc + 3;
    endtask

    task automatic run_cal(input string nm, input int r0, input int bad_idx, input int rbad, input bit mid,
                           input bit e_done, input bit e_fail, input int e_lat, input int e_reads);
        int end_cyc;
        bit seen;
        for (int i = 0; i < 9; i++) resp[i] = r0;
        if (bad_idx > 0) resp[bad_idx] = rbad;
        nreads = 0; tb_done = 0; dv_lat = 0; strb_rand = 1;
        start_req = 1;
        step();
        seen = 0; end_cyc = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (mid && i == 3) start_req = 1;
            step();
            if (cal_done || cal_fail) begin
                seen = 1;
                end_cyc = cyc;
            end
        end
        strb_rand = 0;
        if (!seen) chk({nm, "_finish_timeout"}, 0, 1);
        chk({nm, "_done"}, cal_done, e_done);
        chk({nm, "_fail"}, cal_fail, e_fail);
        chk({nm, "_latency"}, latency, e_lat);
        chk({nm, "_state"}, align_state_prb, e_done ? 5 : 6);
        if (e_done) chk({nm, "_done_delay"}, end_cyc - last_req, e_lat + 1);
        else if (e_reads == 1) chk({nm, "_fail_delay"}, end_cyc - first_req, 16);
        repeat (20) step();
        chk({nm, "_reads"}, nreads, e_reads);
        chk({nm, "_held"}, {cal_done, cal_fail}, {e_done, e_fail});
        tb_done = e_done;
        dv_lat  = e_done ? e_lat : 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        int   r[9];
        int   t, first, cnt, n0;
        bit   d, f;
        int   lat, rd, r0, bad, rbad, mode;

        tbl[0] = '{5, 0, 0, 0, 1, 0, 5 + P, 9};
        tbl[1] = '{5, 3, 6, 0, 0, 1, 5 + P, 4};
        tbl[2] = '{5, 1, 4, 0, 0, 1, 5 + P, 2};
        tbl[3] = '{7, 8, 0, 0, 0, 1, 7 + P, 9};
        tbl[4] = '{0, 0, 0, 0, 0, 1, 0, 1};
        tbl[5] = '{15 - P, 0, 0, 0, 1, 0, 15, 9};
        tbl[6] = '{16 - P, 0, 0, 0, 0, 1, 0, 1};
        tbl[7] = '{2, 0, 0, 0, 1, 0, 2 + P, 9};
        tbl[8] = '{6, 0, 0, 1, 1, 0, 6 + P, 9};

        reset_n = 0; align_start = 0; rd_strb = 0; aligned = '1; q_rise = '0; q_fall = '0;
        for (int i = 0; i < 9; i++) resp[i] = 0;
        repeat (3) step();
        chk("rst_state", align_state_prb, 0);
        chk("rst_outputs", {cal_rd_req, data_valid, cal_done, cal_fail, latency}, 0);
        chk("rst_data", {data_rise, data_fall}, 0);
        reset_n = 1;
        chk_from = cyc + 3;
        repeat (4) step();
        chk("idle_state", align_state_prb, 0);
        chk("idle_reads", nreads, 0);

        for (int i = 0; i < 9; i++) begin
            set_aligned(rnd());
            repeat (4) step();
            run_cal($sformatf("vec%0d", i), tbl[i].r0, tbl[i].bad_idx, tbl[i].rbad, tbl[i].mid,
                    tbl[i].e_done, tbl[i].e_fail, tbl[i].e_lat, tbl[i].e_reads);
        end

        // Back-to-back user strobes after a latency-5 pass.
        run_cal("dvpass", 5, 0, 0, 0, 1, 0, 5 + P, 9);
        strb_req = 1;
        step();
        t = cyc;
        step();
        strb_req = 0;
        first = -1; cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (data_valid) begin
                if (first < 0) first = cyc;
                cnt++;
            end
        end
        chk("dv_first_delay", first - t, 5 + P);
        chk("dv_count", cnt, 2);

        // Strobes after a timeout never become valid.
        run_cal("dvtimeout", 0, 0, 0, 0, 0, 1, 0, 1);
        strb_req = 1;
        repeat (4) step();
        strb_req = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (data_valid) cnt++;
        end
        chk("dv_after_fail", cnt, 0);

        // Half-word re-pairing with the low 16 bits in phase.
        set_aligned(36'h0_0000_FFFF);
        repeat (4) step();
        n0 = cyc + 4;
        bg_r[n0] = 36'h1_2345_6789; bg_f[n0] = 36'hA_BCDE_F013;
        bg_r[n0 + 1] = 36'h5_5AA5_C33C; bg_f[n0 + 1] = 36'h9_0F0F_1E2D;
        while (cyc < n0 + P) step();
        chk("align_A", data_rise, 36'h1_2345_6789);
        chk("align_B", data_fall, 36'hA_BCDE_F013);
        step();
        chk("align_C", data_rise, 36'h5_5AA5_C33C);
        chk("align_D", data_fall, 36'h9_0F0F_1E2D);

        // Reset asserted mid-WAIT.
        for (int i = 0; i < 9; i++) resp[i] = 0;
        nreads = 0; tb_done = 0; dv_lat = 0;
        start_req = 1;
        step();
        repeat (6) step();
        chk("pre_rst_state", align_state_prb, 2);
        chk_from = 1 << 30;
        #1 reset_n = 0;
        #1;
        chk("midrst_state", align_state_prb, 0);
        chk("midrst_outputs", {cal_rd_req, data_valid, cal_done, cal_fail, latency}, 0);
        chk("midrst_data", {data_rise, data_fall}, 0);
        repeat (2) step();
        reset_n = 1;
        pat_at.delete();
        chk_from = cyc + 3;
        nreads = 0;
        repeat (10) step();
        chk("post_rst_state", align_state_prb, 0);
        chk("post_rst_reads", nreads, 0);

        // Randomised calibrations checked against the outcome model.
        for (int k = 0; k < 16; k++) begin
            set_aligned(rnd());
            repeat (4) step();
            mode = $urandom_range(0, 2);
            r0 = $urandom_range(2, 15 - P);
            bad = 0; rbad = 0;
            if (mode == 1) begin
                bad = $urandom_range(1, 8);
                do rbad = $urandom_range(0, 16 - P); while (rbad == r0 || rbad == 1);
            end else if (mode == 2) begin
                r0 = $urandom_range(16 - P, 18);
            end
            for (int i = 0; i < 9; i++) r[i] = r0;
            if (bad > 0) r[bad] = rbad;
            model(r, d, f, lat, rd);
            run_cal($sformatf("rnd%0d", k), r0, bad, rbad, 0, d, f, lat, rd);
            if (d) begin
                for (int i = 0; i < 30; i++) begin
                    strb_req = ($urandom_range(0, 2) != 0);
                    step();
                end
                strb_req = 0;
                repeat (18) step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
